// File: rtl/instrument_pkg.sv
// Shared definitions for the instrument frame demultiplexer: sync byte,
// parser state encoding and channel-index width helper.
package instrument_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } state_t;

  function automatic int ch_idx_width(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/instrument_frame_timeout.sv
// Inter-byte idle counter: pulses expired on the TIMEOUT_CYCLES-th consecutive
// idle cycle while enabled. A kick in that same cycle wins and clears the count.
module instrument_frame_timeout #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES <= 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] idle_cnt;

  // idle_cnt holds the idle cycles already seen, so the current idle cycle is the last one
  assign expired = enable && !kick && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !enable || kick || expired) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/instrument_frame_demux.sv
// Parses sync/header/payload[/checksum] frames from the UART byte stream into
// an addressed bank of instrument registers. Checksum byte enabled by INSTR_CHECKSUM_EN.
//
// state | meaning
// IDLE  | hunting for SYNC_BYTE, other bytes ignored
// HDR   | expecting channel index
// DATA  | collecting DATA_BYTES payload bytes, MSB first
// CSUM  | expecting XOR of header and payload (checksum builds only)
module instrument_frame_demux
  import instrument_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int DATA_BYTES     = 1,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rx_valid,
  input  logic [7:0]                     rx_data,
  output logic [NUM_CH*DATA_BYTES*8-1:0] chan_data,
  output logic [NUM_CH-1:0]              chan_update,
  output logic                           frame_err
);

  localparam int CW  = 8 * DATA_BYTES;
  localparam int CIW = ch_idx_width(NUM_CH);

  state_t           state;
  logic [CIW-1:0]   ch_idx;
  logic [CW-1:0]    payload;
  logic [CW-1:0]    payload_next;
  logic [1:0]       byte_cnt;
  logic             last_byte;
  logic             hdr_ok;
  logic             expired;
  logic             commit;
  logic [CW-1:0]    commit_val;
`ifdef INSTR_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  instrument_frame_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .enable  (state != IDLE),
    .kick    (rx_valid),
    .expired (expired)
  );

  assign payload_next = CW'({payload, rx_data});
  assign last_byte    = (byte_cnt == 2'(DATA_BYTES - 1));
  assign hdr_ok       = (32'(rx_data) < 32'(NUM_CH));

  // Commit decision is shared by the parser and the channel bank
  always_comb begin
    commit     = 1'b0;
    commit_val = payload_next;
    if (rx_valid) begin
`ifdef INSTR_CHECKSUM_EN
      if (state == CSUM) begin
        commit     = (rx_data == csum);
        commit_val = payload;
      end
`else
      if (state == DATA) begin
        commit = last_byte;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ch_idx    <= '0;
      payload   <= '0;
      byte_cnt  <= '0;
      frame_err <= 1'b0;
`ifdef INSTR_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      frame_err <= 1'b0;
      if (expired) begin
        state     <= IDLE;
        frame_err <= 1'b1;
      end else if (rx_valid) begin
        case (state)
          IDLE: begin
            if (rx_data == SYNC_BYTE) state <= HDR;
          end
          HDR: begin
            if (hdr_ok) begin
              ch_idx   <= rx_data[CIW-1:0];
              byte_cnt <= '0;
`ifdef INSTR_CHECKSUM_EN
              csum     <= rx_data;
`endif
              state    <= DATA;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end
          DATA: begin
            payload  <= payload_next;
            byte_cnt <= byte_cnt + 2'd1;
`ifdef INSTR_CHECKSUM_EN
            csum     <= csum ^ rx_data;
            if (last_byte) state <= CSUM;
`else
            if (last_byte) state <= IDLE;
`endif
          end
`ifdef INSTR_CHECKSUM_EN
          CSUM: begin
            if (!commit) frame_err <= 1'b1;
            state <= IDLE;
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chan_data   <= '0;
      chan_update <= '0;
    end else begin
      chan_update <= '0;
      if (commit) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (ch_idx == CIW'(k)) begin
            chan_data[k*CW +: CW] <= commit_val;
            chan_update[k]        <= 1'b1;
          end
        end
      end
    end
  end

endmodule
